// File: rtl/clk_div_phase.sv
// rtl/clk_div_phase.sv - runtime-programmable phase divider with clock stretching
module clk_div_phase_bufg (
  input  logic clk_i,
  output logic clk_o
);
  // Stand-in for the vendor global clock buffer; the FPGA flow binds the real primitive here.
  assign clk_o = clk_i;
endmodule

module clk_div_phase #(
  parameter int DIV_W       = 16,
  parameter int NUM_PHASES  = 4,
  parameter int DEFAULT_DIV = 124,
  parameter int XILINX      = 0
) (
  input  logic                  clk_i,
  input  logic                  arstn_i,
  input  logic                  en_i,
  input  logic [DIV_W-1:0]      div_i,
  input  logic                  div_vld_i,
  output logic                  div_rdy_o,
  input  logic                  stretch_i,
  output logic                  clk_o,
  output logic [NUM_PHASES-1:0] phase_o,
  output logic                  stretch_o
);

  localparam int PH_W = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1;
  localparam logic [PH_W-1:0] HALF_PH = PH_W'(NUM_PHASES / 2);
  localparam logic [PH_W-1:0] LAST_PH = PH_W'(NUM_PHASES - 1);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] pend_q, pend_d;
  logic [PH_W-1:0]  phase_q, phase_d;
  logic [PH_W-1:0]  next_phase;
  logic             clk_q, clk_d;
  logic             pend_vld_q, pend_vld_d;
  logic             stall;
  logic             advance;
  logic             cnt_end;
  logic             period_end;

  // Stretch can only hold the counter on the very first cycle of the high half.
  always_comb begin
    stall      = (phase_q == HALF_PH) && (cnt_q == '0) && stretch_i;
    advance    = en_i && !stall;
    cnt_end    = (cnt_q == div_q);
    next_phase = (phase_q == LAST_PH) ? '0 : phase_q + PH_W'(1);
    period_end = advance && cnt_end && (phase_q == LAST_PH);
  end

  // Phase counter; clk_q is registered together with the phase so clk_o never glitches.
  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    clk_d   = clk_q;
    if (advance) begin
      if (cnt_end) begin
        cnt_d   = '0;
        phase_d = next_phase;
        clk_d   = (next_phase >= HALF_PH);
      end else begin
        cnt_d = cnt_q + DIV_W'(1);
      end
    end
  end

  // Divide-value handshake; a pending value only takes effect on a period boundary.
  always_comb begin
    div_d      = div_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    if (pend_vld_q) begin
      if (period_end) begin
        div_d      = pend_q;
        pend_vld_d = 1'b0;
      end
    end else if (div_vld_i) begin
      pend_d     = div_i;
      pend_vld_d = 1'b1;
    end
  end

  // Phase strobes decoded straight from state so the bit engine sees them with no latency.
  always_comb begin
    phase_o = '0;
    if (advance && (cnt_q == '0)) begin
      for (int k = 0; k < NUM_PHASES; k++) begin
        phase_o[k] = (phase_q == PH_W'(k));
      end
    end
    stretch_o = stall && en_i;
    div_rdy_o = !pend_vld_q;
  end

  // State registers; reset discards any pending divide value.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      cnt_q      <= '0;
      phase_q    <= '0;
      clk_q      <= 1'b0;
      div_q      <= DIV_W'(DEFAULT_DIV);
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      phase_q    <= phase_d;
      clk_q      <= clk_d;
      div_q      <= div_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
    end
  end

  generate
    if (XILINX != 0) begin : g_bufg
      clk_div_phase_bufg u_bufg (
        .clk_i (clk_q),
        .clk_o (clk_o)
      );
    end else begin : g_direct
      assign clk_o = clk_q;
    end
  endgenerate

endmodule

// File: tb/tb_clk_div_phase.sv
// tb/tb_clk_div_phase.sv - self-checking bench for clk_div_phase
module tb_clk_div_phase;

  localparam int NP   = 4;
  localparam int HALF = NP / 2;
  localparam int DW   = 16;
  localparam int DDIV = 1;

  logic          clk_i = 1'b0;
  logic          arstn_i;
  logic          en_i;
  logic [DW-1:0] div_i;
  logic          div_vld_i;
  logic          div_rdy_o;
  logic          stretch_i;
  logic          clk_o;
  logic [NP-1:0] phase_o;
  logic          stretch_o;

  clk_div_phase #(
    .DIV_W       (DW),
    .NUM_PHASES  (NP),
    .DEFAULT_DIV (DDIV),
    .XILINX      (0)
  ) dut (
    .clk_i     (clk_i),
    .arstn_i   (arstn_i),
    .en_i      (en_i),
    .div_i     (div_i),
    .div_vld_i (div_vld_i),
    .div_rdy_o (div_rdy_o),
    .stretch_i (stretch_i),
    .clk_o     (clk_o),
    .phase_o   (phase_o),
    .stretch_o (stretch_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  // Reference model: position within the period as a plain integer tick count.
  int      m_t;
  int      m_div;
  int      m_pend;
  bit      m_pend_vld;
  bit      cur_en, cur_st, cur_vld;
  int      cur_div;
  logic [NP-1:0] e_phase;
  logic    e_clk, e_str, e_rdy;

  task automatic model_reset();
    m_t = 0; m_div = DDIV; m_pend = 0; m_pend_vld = 0;
  endtask

  task automatic model_eval();
    int len;
    bit st;
    logic [NP-1:0] one;
    one = 1;
    len = m_div + 1;
    st = cur_st && (m_t == HALF * len);
    e_phase = (cur_en && !st && (m_t % len == 0)) ? (one << (m_t / len)) : '0;
    e_clk = ((m_t / len) >= HALF);
    e_str = st && cur_en;
    e_rdy = !m_pend_vld;
  endtask

  task automatic model_step();
    int len;
    bit st, old_pv;
    len = m_div + 1;
    st = cur_st && (m_t == HALF * len);
    old_pv = m_pend_vld;
    if (cur_en && !st) begin
      if (m_t == NP * len - 1) begin
        m_t = 0;
        if (old_pv) begin
          m_div = m_pend;
          m_pend_vld = 0;
        end
      end else begin
        m_t = m_t + 1;
      end
    end
    if (cur_vld && !old_pv) begin
      m_pend = cur_div;
      m_pend_vld = 1;
    end
  endtask

  task automatic tick(input bit en, input bit st, input bit vld, input int dv);
    @(posedge clk_i);
    if (arstn_i) model_step();
    #1;
    en_i = en; stretch_i = st; div_vld_i = vld; div_i = DW'(dv);
    cur_en = en; cur_st = st; cur_vld = vld; cur_div = dv;
    @(negedge clk_i);
    model_eval();
  endtask

  task automatic do_reset();
    @(posedge clk_i); #1;
    en_i = 0; stretch_i = 0; div_vld_i = 0; div_i = '0;
    cur_en = 0; cur_st = 0; cur_vld = 0; cur_div = 0;
    arstn_i = 1'b0;
    model_reset();
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    arstn_i = 1'b1;
    model_eval();
  endtask

  task automatic wait_phase0(input string name);
    int guard;
    guard = 0;
    while (phase_o[0] !== 1'b1 && guard < 100) begin
      tick(1, 0, 0, 0);
      guard++;
    end
    if (guard >= 100) begin
      checks++; errors++;
      $display("FAIL %s timeout waiting for phase_o[0] got %b", name, phase_o);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (div_rdy_o !== 1'b1) begin errors++; $display("FAIL reset_rdy got %b exp 1", div_rdy_o); end
    checks++; if (phase_o !== '0) begin errors++; $display("FAIL reset_phase got %b exp 0000", phase_o); end
    checks++; if (stretch_o !== 1'b0) begin errors++; $display("FAIL reset_stretch got %b exp 0", stretch_o); end
    checks++; if (clk_o !== 1'b0) begin errors++; $display("FAIL reset_clk got %b exp 0", clk_o); end
    tick(1, 0, 0, 0);
    checks++; if (phase_o !== 4'b0001) begin errors++; $display("FAIL first_strobe got %b exp 0001", phase_o); end
  endtask

  task automatic test_basic();
    int first [NP];
    int hi, second0;
    for (int k = 0; k < NP; k++) first[k] = -1;
    hi = 0; second0 = -1;
    for (int c = 0; c < 16; c++) begin
      if (c > 0) tick(1, 0, 0, 0);
      checks++; if (phase_o !== e_phase) begin errors++; $display("FAIL basic_phase c=%0d got %b exp %b", c, phase_o, e_phase); end
      checks++; if (clk_o !== e_clk) begin errors++; $display("FAIL basic_clk c=%0d got %b exp %b", c, clk_o, e_clk); end
      for (int k = 0; k < NP; k++) if (phase_o[k] === 1'b1 && first[k] < 0) first[k] = c;
      if (c > 0 && phase_o[0] === 1'b1 && second0 < 0) second0 = c;
      if (c < 8 && clk_o === 1'b1) hi++;
    end
    for (int k = 0; k < NP; k++) begin
      checks++; if (first[k] != 2 * k) begin errors++; $display("FAIL basic_strobe_at k=%0d got %0d exp %0d", k, first[k], 2 * k); end
    end
    checks++; if (hi != 4) begin errors++; $display("FAIL basic_high_cycles got %0d exp 4", hi); end
    checks++; if (second0 != 8) begin errors++; $display("FAIL basic_period got %0d exp 8", second0); end
  endtask

  task automatic test_div_update();
    int guard, n;
    guard = 0;
    while (m_t != 3 && guard < 40) begin tick(1, 0, 0, 0); guard++; end
    tick(1, 0, 1, 3);
    n = 0;
    do begin
      tick(1, 0, 0, 0);
      n++;
      checks++; if (phase_o !== e_phase) begin errors++; $display("FAIL upd_phase n=%0d got %b exp %b", n, phase_o, e_phase); end
      if (n == 1) begin
        checks++; if (div_rdy_o !== 1'b0) begin errors++; $display("FAIL upd_rdy_low got %b exp 0", div_rdy_o); end
      end
    end while (phase_o[0] !== 1'b1 && n < 40);
    checks++; if (n != 4) begin errors++; $display("FAIL upd_old_period_rest got %0d exp 4", n); end
    checks++; if (div_rdy_o !== 1'b1) begin errors++; $display("FAIL upd_rdy_back got %b exp 1", div_rdy_o); end
    n = 0;
    do begin
      tick(1, 0, 0, 0);
      n++;
      checks++; if (clk_o !== e_clk) begin errors++; $display("FAIL upd_clk n=%0d got %b exp %b", n, clk_o, e_clk); end
    end while (phase_o[0] !== 1'b1 && n < 40);
    checks++; if (n != 16) begin errors++; $display("FAIL upd_new_period got %0d exp 16", n); end
  endtask

  task automatic test_stretch();
    int scount, p2, p0;
    scount = 0; p2 = -1; p0 = -1;
    wait_phase0("stretch");
    for (int c = 1; c <= 40; c++) begin
      tick(1, (c >= 6 && c <= 12), 0, 0);
      checks++; if (phase_o !== e_phase) begin errors++; $display("FAIL str_phase c=%0d got %b exp %b", c, phase_o, e_phase); end
      checks++; if (stretch_o !== e_str) begin errors++; $display("FAIL str_flag c=%0d got %b exp %b", c, stretch_o, e_str); end
      checks++; if (clk_o !== e_clk) begin errors++; $display("FAIL str_clk c=%0d got %b exp %b", c, clk_o, e_clk); end
      if (stretch_o === 1'b1) scount++;
      if (phase_o[2] === 1'b1 && p2 < 0) p2 = c;
      if (phase_o[0] === 1'b1) begin p0 = c; break; end
    end
    checks++; if (scount != 5) begin errors++; $display("FAIL str_cycles got %0d exp 5", scount); end
    checks++; if (p2 != 13) begin errors++; $display("FAIL str_phase2_at got %0d exp 13", p2); end
    checks++; if (p0 != 21) begin errors++; $display("FAIL str_period got %0d exp 21", p0); end
  endtask

  task automatic test_enable();
    int p0;
    bit en;
    p0 = -1;
    wait_phase0("enable");
    for (int c = 1; c <= 40; c++) begin
      en = !(c >= 5 && c <= 7);
      tick(en, 0, 0, 0);
      checks++; if (phase_o !== e_phase) begin errors++; $display("FAIL en_phase c=%0d got %b exp %b", c, phase_o, e_phase); end
      checks++; if (clk_o !== e_clk) begin errors++; $display("FAIL en_clk c=%0d got %b exp %b", c, clk_o, e_clk); end
      if (phase_o[0] === 1'b1) begin p0 = c; break; end
    end
    checks++; if (p0 != 19) begin errors++; $display("FAIL en_period got %0d exp 19", p0); end
  endtask

  task automatic test_reset_mid();
    int guard, n;
    guard = 0;
    while (m_t != 3 * (m_div + 1) + 1 && guard < 40) begin tick(1, 0, 0, 0); guard++; end
    tick(1, 0, 1, 7);
    tick(1, 0, 0, 0);
    checks++; if (div_rdy_o !== 1'b0) begin errors++; $display("FAIL rst_pending got %b exp 0", div_rdy_o); end
    #2;
    arstn_i = 1'b0; en_i = 1'b0; cur_en = 0;
    model_reset();
    #1;
    checks++; if (clk_o !== 1'b0) begin errors++; $display("FAIL rst_mid_clk got %b exp 0", clk_o); end
    checks++; if (phase_o !== '0) begin errors++; $display("FAIL rst_mid_phase got %b exp 0000", phase_o); end
    checks++; if (div_rdy_o !== 1'b1) begin errors++; $display("FAIL rst_mid_rdy got %b exp 1", div_rdy_o); end
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    arstn_i = 1'b1;
    model_eval();
    tick(1, 0, 0, 0);
    checks++; if (phase_o !== 4'b0001) begin errors++; $display("FAIL rst_restart got %b exp 0001", phase_o); end
    n = 0;
    do begin tick(1, 0, 0, 0); n++; end while (phase_o[0] !== 1'b1 && n < 40);
    checks++; if (n != 8) begin errors++; $display("FAIL rst_default_period got %0d exp 8", n); end
  endtask

  task automatic test_div_zero();
    int guard;
    logic [NP-1:0] one;
    one = 1;
    guard = 0;
    while (!e_rdy && guard < 60) begin tick(1, 0, 0, 0); guard++; end
    tick(1, 0, 1, 0);
    tick(1, 0, 0, 0);
    guard = 0;
    while (!e_rdy && guard < 60) begin tick(1, 0, 0, 0); guard++; end
    for (int c = 0; c < 12; c++) begin
      if (c > 0) tick(1, 0, 0, 0);
      checks++; if (phase_o !== (one << (c % NP))) begin errors++; $display("FAIL div0_phase c=%0d got %b exp %b", c, phase_o, one << (c % NP)); end
      checks++; if (clk_o !== ((c % NP) >= HALF)) begin errors++; $display("FAIL div0_clk c=%0d got %b exp %b", c, clk_o, (c % NP) >= HALF); end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      tick($urandom_range(9, 0) != 0, $urandom_range(2, 0) == 0,
           $urandom_range(9, 0) == 0, int'($urandom_range(3, 0)));
      checks++; if (phase_o !== e_phase) begin errors++; $display("FAIL rnd_phase i=%0d got %b exp %b", i, phase_o, e_phase); end
      checks++; if (clk_o !== e_clk) begin errors++; $display("FAIL rnd_clk i=%0d got %b exp %b", i, clk_o, e_clk); end
      checks++; if (stretch_o !== e_str) begin errors++; $display("FAIL rnd_stretch i=%0d got %b exp %b", i, stretch_o, e_str); end
      checks++; if (div_rdy_o !== e_rdy) begin errors++; $display("FAIL rnd_rdy i=%0d got %b exp %b", i, div_rdy_o, e_rdy); end
    end
  endtask

  initial begin
    arstn_i = 1'b0; en_i = 1'b0; stretch_i = 1'b0; div_vld_i = 1'b0; div_i = '0;
    test_reset();
    test_basic();
    test_div_update();
    test_stretch();
    test_enable();
    test_reset_mid();
    test_div_zero();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
